// File: rtl/conv_sched.sv
// conv_sched: per-layer sequencer for the 5x5 streaming convolution engine.
//
// For one layer it loops over N_KERNEL kernels. Each kernel pass loads K*K weights into the
// engine, streams every fmap column of every K-row band as tap reads, captures engine results
// into the result memory, and waits for the engine's done pulse.
//
// Ports
//   clk, rstn        clock (rising edge) and synchronous active-low reset
//   go, layer        start pulse and size select (0: 28x28, 1: 12x12), sampled on accepted go
//   conv_ovalid      engine result valid, one per output pixel
//   conv_done        engine pass-complete pulse
//   conv_start       engine run enable, high for the whole per-kernel pass
//   conv_weight_en   engine weight capture strobe (w_rd_en delayed by the 1-cycle memory)
//   conv_state       engine size select (latched layer)
//   w_rd_en/addr     weight memory read port, addr = kidx*K*K + i
//   f_rd_en/row/col  fmap column read, row = top of current K-row band
//   o_wr_en/addr     result memory write port, addr = kidx*Osz*Osz + pix
//   kidx             current kernel index
//   busy             high from accepted go until layer_done or error abort
//   layer_done       1-cycle pulse after the last kernel completes
//   err              sticky error flag, cleared on the next accepted go
module conv_sched #(
    parameter int unsigned K        = 5,
    parameter int unsigned N_KERNEL = 6,
    parameter int unsigned WA_W     = 10,
    parameter int unsigned OA_W     = 12,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            go,
    input  logic            layer,
    input  logic            conv_ovalid,
    input  logic            conv_done,
    output logic            conv_start,
    output logic            conv_weight_en,
    output logic            conv_state,
    output logic            w_rd_en,
    output logic [WA_W-1:0] w_rd_addr,
    output logic            f_rd_en,
    output logic [4:0]      f_row,
    output logic [4:0]      f_col,
    output logic            o_wr_en,
    output logic [OA_W-1:0] o_wr_addr,
    output logic [2:0]      kidx,
    output logic            busy,
    output logic            layer_done,
    output logic            err
);

    localparam int unsigned WPerK = K * K;
    localparam int unsigned WcW   = $clog2(WPerK + 1);
    localparam int unsigned TcW   = $clog2(TIMEOUT);

    localparam logic [4:0]      Ni0     = 5'd28;
    localparam logic [4:0]      Ni1     = 5'd12;
    localparam logic [OA_W-1:0] OszSq0  = OA_W'((28 - K + 1) * (28 - K + 1));
    localparam logic [OA_W-1:0] OszSq1  = OA_W'((12 - K + 1) * (12 - K + 1));
    localparam logic [WcW-1:0]  WcLast  = WcW'(WPerK);
    localparam logic [TcW-1:0]  TmoLast = TcW'(TIMEOUT - 1);
    localparam logic [2:0]      KLast   = 3'(N_KERNEL - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StStream,
        StWaitDone,
        StNext,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic            layer_q, layer_d;
    logic [2:0]      kidx_q, kidx_d;
    logic [WcW-1:0]  w_cnt_q, w_cnt_d;
    logic            wen_q, wen_d;
    logic [4:0]      row_q, row_d;
    logic [4:0]      col_q, col_d;
    logic [OA_W-1:0] pix_q, pix_d;
    logic [TcW-1:0]  tmo_q, tmo_d;
    logic            err_q, err_d;

    logic [4:0]      ni;
    logic [4:0]      row_last;
    logic [4:0]      col_last;
    logic [OA_W-1:0] osz_sq;
    logic [OA_W-1:0] pix_next;
    logic            start_ok;
    logic            load_last;
    logic            stream_last;
    logic            tmo_hit;
    logic            kidx_last;

    // Geometry of the latched layer.
    always_comb begin
        ni       = layer_q ? Ni1 : Ni0;
        col_last = ni - 5'd1;
        row_last = ni - 5'(K);
        osz_sq   = layer_q ? OszSq1 : OszSq0;
    end

    assign start_ok    = go && !busy;
    // Load phase ends one cycle after the last read, when its strobe reaches the engine.
    assign load_last   = (state_q == StLoadW) && (w_cnt_q == WcLast);
    assign stream_last = (state_q == StStream) && (col_q == col_last) && (row_q == row_last);
    assign tmo_hit     = (state_q == StWaitDone) && !conv_done && (tmo_q == TmoLast);
    assign kidx_last   = (kidx_q == KLast);

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start_ok) state_d = StLoadW;
            StLoadW:    if (load_last) state_d = StStream;
            StStream:   if (stream_last) state_d = StWaitDone;
            StWaitDone: begin
                if (conv_done) begin
                    state_d = StNext;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                end
            end
            StNext:     state_d = kidx_last ? StDone : StLoadW;
            StDone:     state_d = start_ok ? StLoadW : StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Output decode.
    always_comb begin
        conv_start = 1'b0;
        w_rd_en    = 1'b0;
        f_rd_en    = 1'b0;
        layer_done = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            StIdle:     busy = 1'b0;
            StLoadW: begin
                conv_start = 1'b1;
                w_rd_en    = (w_cnt_q < WcLast);
            end
            StStream: begin
                conv_start = 1'b1;
                f_rd_en    = 1'b1;
            end
            StWaitDone: conv_start = 1'b1;
            StNext:     busy = 1'b1;
            StDone: begin
                busy       = 1'b0;
                layer_done = 1'b1;
            end
            default:    busy = 1'b0;
        endcase
    end

    // conv_start is high exactly while a pass is in progress.
    assign o_wr_en        = conv_ovalid && conv_start;
    assign conv_weight_en = wen_q;
    assign conv_state     = layer_q;
    assign kidx           = kidx_q;
    assign f_row          = row_q;
    assign f_col          = col_q;
    assign err            = err_q;
    assign w_rd_addr      = WA_W'(kidx_q) * WA_W'(WPerK) + WA_W'(w_cnt_q);
    assign o_wr_addr      = OA_W'(kidx_q) * osz_sq + pix_q;

    // Counters and error flag.
    always_comb begin
        layer_d  = layer_q;
        kidx_d   = kidx_q;
        w_cnt_d  = w_cnt_q;
        wen_d    = w_rd_en;
        row_d    = row_q;
        col_d    = col_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        // A write coinciding with conv_done is counted before the pixel check.
        pix_next = pix_q + OA_W'(o_wr_en);
        pix_d    = pix_next;

        if (start_ok) begin
            layer_d = layer;
            kidx_d  = 3'd0;
            w_cnt_d = '0;
            row_d   = 5'd0;
            col_d   = 5'd0;
            pix_d   = '0;
            tmo_d   = '0;
            err_d   = 1'b0;
        end

        unique case (state_q)
            StLoadW: begin
                w_cnt_d = load_last ? '0 : w_cnt_q + WcW'(1);
            end
            StStream: begin
                if (col_q == col_last) begin
                    col_d = 5'd0;
                    row_d = (row_q == row_last) ? 5'd0 : row_q + 5'd1;
                end else begin
                    col_d = col_q + 5'd1;
                end
            end
            StWaitDone: begin
                if (conv_done) begin
                    tmo_d = '0;
                    if (pix_next != osz_sq) err_d = 1'b1;
                end else if (tmo_hit) begin
                    tmo_d = '0;
                    err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TcW'(1);
                end
            end
            StNext: begin
                pix_d = '0;
                if (!kidx_last) kidx_d = kidx_q + 3'd1;
            end
            default: begin
            end
        endcase

        // Results arriving outside a pass are dropped but flagged.
        if (conv_ovalid && !conv_start) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            layer_q <= 1'b0;
            kidx_q  <= 3'd0;
            w_cnt_q <= '0;
            wen_q   <= 1'b0;
            row_q   <= 5'd0;
            col_q   <= 5'd0;
            pix_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            layer_q <= layer_d;
            kidx_q  <= kidx_d;
            w_cnt_q <= w_cnt_d;
            wen_q   <= wen_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pix_q   <= pix_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched with a behavioural engine model that answers each pass with a
// programmable number of result strobes, the last one carrying conv_done.
module tb_conv_sched;

    localparam int unsigned WA_W = 10;
    localparam int unsigned OA_W = 12;

    logic            clk;
    logic            rstn;
    logic            go;
    logic            layer;
    logic            conv_ovalid;
    logic            conv_done;
    logic            conv_start;
    logic            conv_weight_en;
    logic            conv_state;
    logic            w_rd_en;
    logic [WA_W-1:0] w_rd_addr;
    logic            f_rd_en;
    logic [4:0]      f_row;
    logic [4:0]      f_col;
    logic            o_wr_en;
    logic [OA_W-1:0] o_wr_addr;
    logic [2:0]      kidx;
    logic            busy;
    logic            layer_done;
    logic            err;

    conv_sched dut (
        .clk            (clk),
        .rstn           (rstn),
        .go             (go),
        .layer          (layer),
        .conv_ovalid    (conv_ovalid),
        .conv_done      (conv_done),
        .conv_start     (conv_start),
        .conv_weight_en (conv_weight_en),
        .conv_state     (conv_state),
        .w_rd_en        (w_rd_en),
        .w_rd_addr      (w_rd_addr),
        .f_rd_en        (f_rd_en),
        .f_row          (f_row),
        .f_col          (f_col),
        .o_wr_en        (o_wr_en),
        .o_wr_addr      (o_wr_addr),
        .kidx           (kidx),
        .busy           (busy),
        .layer_done     (layer_done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_vec;
    int n_err;

    // Per-run observations.
    int n_wrd, w_bad, n_wen, wen_bad, n_wburst;
    int n_frd, f_bad, exp_w, exp_row, exp_col, exp_ni;
    int n_owr, o_bad, owen_bad, max_o, osq, mk, mp;
    int n_ld, n_gap, n_wait;
    logic prev_wrd;
    logic stream_seen;

    // Engine model settings.
    int eng_nval;
    int eng_left;
    logic done_en;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_wrd = 0; w_bad = 0; n_wen = 0; wen_bad = 0; n_wburst = 0;
        n_frd = 0; f_bad = 0; exp_w = 0; exp_row = 0; exp_col = 0;
        n_owr = 0; o_bad = 0; owen_bad = 0; max_o = -1; mk = 0; mp = 0;
        n_ld = 0; n_gap = 0; n_wait = 0;
        stream_seen = 1'b0;
    endtask

    // One clock: sample at the falling edge, then drive the engine for the next rising edge.
    task automatic cycle();
        logic waiting;
        @(negedge clk);
        if (w_rd_en) begin
            n_wrd++;
            if (int'(w_rd_addr) != exp_w) w_bad++;
            exp_w++;
            if (!prev_wrd) n_wburst++;
        end
        if (conv_weight_en) n_wen++;
        if (conv_weight_en != prev_wrd) wen_bad++;
        prev_wrd = w_rd_en;
        if (f_rd_en) begin
            n_frd++;
            stream_seen = 1'b1;
            if (int'(f_row) != exp_row || int'(f_col) != exp_col) f_bad++;
            exp_col++;
            if (exp_col == exp_ni) begin
                exp_col = 0;
                exp_row++;
                if (exp_row == exp_ni - 4) exp_row = 0;
            end
        end
        if (layer_done) n_ld++;
        if (busy && !conv_start) begin
            n_gap++;
            mk++;
            mp = 0;
        end
        waiting = conv_start && stream_seen && !f_rd_en;
        if (waiting) n_wait++;
        if (!conv_start) begin
            stream_seen = 1'b0;
            eng_left = eng_nval;
        end
        conv_ovalid = 1'b0;
        conv_done   = 1'b0;
        if (waiting && eng_left > 0) begin
            conv_ovalid = 1'b1;
            eng_left--;
            if (eng_left == 0 && done_en) conv_done = 1'b1;
        end
        #1;
        if (o_wr_en != conv_ovalid) owen_bad++;
        if (o_wr_en) begin
            n_owr++;
            if (int'(o_wr_addr) != mk * osq + mp) o_bad++;
            if (int'(o_wr_addr) > max_o) max_o = int'(o_wr_addr);
            mp++;
        end
    endtask

    task automatic start_layer(input logic lay, input int nval, input logic den);
        clear_stats();
        layer    = lay;
        exp_ni   = lay ? 12 : 28;
        osq      = lay ? 64 : 576;
        eng_nval = nval;
        eng_left = nval;
        done_en  = den;
        go = 1'b1;
        cycle();
        go = 1'b0;
    endtask

    // Runs a layer until busy drops; glitch_at >= 0 pulses go (with the other layer) mid-run.
    task automatic run_layer(input logic lay, input int nval, input logic den,
                             input int glitch_at, input int budget);
        int i;
        start_layer(lay, nval, den);
        check("go_busy", int'(busy), 1);
        check("go_err_clear", int'(err), 0);
        check("go_w_rd_en", int'(w_rd_en), 1);
        check("go_w_rd_addr", int'(w_rd_addr), 0);
        check("go_weight_en", int'(conv_weight_en), 0);
        check("conv_state", int'(conv_state), int'(lay));
        i = 0;
        while (busy && i < budget) begin
            if (i == glitch_at) begin
                check("go_in_stream", int'(f_rd_en), 1);
                go    = 1'b1;
                layer = ~lay;
            end
            cycle();
            go    = 1'b0;
            layer = lay;
            i++;
        end
        check("run_in_budget", int'(i < budget), 1);
        cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, int'({conv_start, conv_weight_en, conv_state, w_rd_en, f_rd_en,
                                   o_wr_en, busy, layer_done, err, kidx, f_row, f_col}), 0);
        check({tag, "_waddr"}, int'(w_rd_addr), 0);
        check({tag, "_oaddr"}, int'(o_wr_addr), 0);
    endtask

    initial begin
        int i;
        n_vec = 0; n_err = 0;
        rstn = 1'b0; go = 1'b0; layer = 1'b0; conv_ovalid = 1'b0; conv_done = 1'b0;
        eng_nval = 0; eng_left = 0; done_en = 1'b0; prev_wrd = 1'b0; exp_ni = 12; osq = 64;
        clear_stats();
        repeat (3) cycle();
        check_all_zero("reset");
        rstn = 1'b1;
        cycle();

        // Small layer, all kernels, exact result counts.
        run_layer(1'b1, 64, 1'b1, -1, 3000);
        check("l1_w_reads", n_wrd, 150);
        check("l1_w_addr_seq", w_bad, 0);
        check("l1_w_bursts", n_wburst, 6);
        check("l1_weight_en", n_wen, 150);
        check("l1_wen_delay", wen_bad, 0);
        check("l1_f_reads", n_frd, 576);
        check("l1_f_order", f_bad, 0);
        check("l1_o_writes", n_owr, 384);
        check("l1_o_addr", o_bad, 0);
        check("l1_o_en", owen_bad, 0);
        check("l1_o_max", max_o, 383);
        check("l1_start_gaps", n_gap, 6);
        check("l1_layer_done", n_ld, 1);
        check("l1_err", int'(err), 0);
        check("l1_idle", int'(busy), 0);

        // Large layer with a go (other layer) pulsed mid-stream, which must be ignored.
        run_layer(1'b0, 576, 1'b1, 200, 10000);
        check("l0_w_reads", n_wrd, 150);
        check("l0_w_addr_seq", w_bad, 0);
        check("l0_w_bursts", n_wburst, 6);
        check("l0_f_reads", n_frd, 4032);
        check("l0_f_order", f_bad, 0);
        check("l0_o_writes", n_owr, 3456);
        check("l0_o_addr", o_bad, 0);
        check("l0_o_max", max_o, 3455);
        check("l0_start_gaps", n_gap, 6);
        check("l0_layer_done", n_ld, 1);
        check("l0_err", int'(err), 0);

        // Engine never signals done: timeout after exactly TIMEOUT waiting cycles.
        run_layer(1'b1, 64, 1'b0, -1, 3000);
        check("to_wait_cycles", n_wait, 1024);
        check("to_err", int'(err), 1);
        check("to_busy", int'(busy), 0);
        check("to_no_layer_done", n_ld, 0);
        check("to_no_next", n_gap, 0);

        // One result short per kernel: error but the layer still completes.
        run_layer(1'b1, 63, 1'b1, -1, 3000);
        check("short_o_writes", n_owr, 378);
        check("short_o_addr", o_bad, 0);
        check("short_err", int'(err), 1);
        check("short_layer_done", n_ld, 1);
        check("short_start_gaps", n_gap, 6);

        // Reset for one cycle in the middle of a stream.
        start_layer(1'b0, 576, 1'b1);
        i = 0;
        while (!(f_rd_en && f_row == 5'd2 && f_col == 5'd10) && i < 2000) begin
            cycle();
            i++;
        end
        check("mid_stream_reached", int'(f_rd_en), 1);
        rstn = 1'b0;
        cycle();
        check_all_zero("mid_reset");
        rstn = 1'b1;
        cycle();
        check("post_reset_ld", n_ld, 0);
        run_layer(1'b1, 64, 1'b1, -1, 3000);
        check("rr_f_order", f_bad, 0);
        check("rr_o_writes", n_owr, 384);
        check("rr_o_addr", o_bad, 0);
        check("rr_layer_done", n_ld, 1);
        check("rr_err", int'(err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
